// File: rtl/ioctl_word_packer.sv
// Packs the byte-wide ioctl download stream into 16-bit little-endian word writes with byte enables.
// Optional macro IOCTL_PACKER_STATS_EN adds the stat_words counter of words written to memory.
module ioctl_word_packer #(
   parameter int FIFO_AW = 3,
   parameter int ADDR_W  = 25
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              ioctl_download,
   input  logic              ioctl_wr,
   input  logic [ADDR_W-1:0] ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   output logic              mem_req,
   input  logic              mem_ack,
   output logic [ADDR_W-2:0] mem_addr,
   output logic [15:0]       mem_din,
   output logic [1:0]        mem_be,
   output logic              busy,
   output logic              done,
   output logic              overflow
`ifdef IOCTL_PACKER_STATS_EN
   ,
   output logic [15:0]       stat_words
`endif
);

   localparam int WA    = ADDR_W - 1;
   localparam int DEPTH = 1 << FIFO_AW;
   localparam int EW    = WA + 18;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DRAIN} state_t;

   state_t state, state_nxt;
   logic   dl_q;
   logic   rise;

   logic [WA-1:0] pend_addr, pend_addr_nxt;
   logic [15:0]   pend_data, pend_data_nxt;
   logic [1:0]    pend_be, pend_be_nxt;
   logic          pend_v, pend_v_nxt;

   logic          push_v;
   logic [WA-1:0] push_addr;
   logic [15:0]   push_data;
   logic [1:0]    push_be;

   logic [EW-1:0]    fifo_mem [DEPTH];
   logic [FIFO_AW:0] wr_ptr, rd_ptr;
   logic             fifo_empty, fifo_full, pop, push_ok, drop;
   logic [EW-1:0]    head;

   logic          byte_v, pv, lane;
   logic [WA-1:0] byte_waddr;
   logic [1:0]    lane_be, merged_be;
   logic [15:0]   lane_data, merged_data;

   assign rise       = ioctl_download && !dl_q;
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                       (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
   assign pop        = mem_req && mem_ack;
   assign push_ok    = push_v && (!fifo_full || pop);
   assign drop       = push_v && fifo_full && !pop;
   assign head       = fifo_mem[rd_ptr[FIFO_AW-1:0]];

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state <= S_IDLE;
         dl_q  <= 1'b0;
      end else begin
         state <= state_nxt;
         dl_q  <= ioctl_download;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (rise) state_nxt = S_RUN;
         S_RUN:   if (!ioctl_download) state_nxt = S_FLUSH;
         S_FLUSH: state_nxt = rise ? S_RUN : S_DRAIN;
         S_DRAIN: begin
            if (rise) state_nxt = S_RUN;
            else if (fifo_empty && !mem_req) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state != S_IDLE) || pend_v || !fifo_empty || mem_req;
      done = (state == S_DRAIN) && fifo_empty && !mem_req && !rise;
   end

   // A download rise invalidates the pending word, so a byte in that cycle starts fresh.
   always_comb begin
      byte_v      = ioctl_wr && ioctl_download;
      pv          = pend_v && !rise;
      lane        = ioctl_addr[0];
      byte_waddr  = ioctl_addr[ADDR_W-1:1];
      lane_be     = lane ? 2'b10 : 2'b01;
      lane_data   = lane ? {ioctl_dout, 8'h00} : {8'h00, ioctl_dout};
      merged_be   = pend_be | lane_be;
      merged_data = lane ? {ioctl_dout, pend_data[7:0]} : {pend_data[15:8], ioctl_dout};

      pend_addr_nxt = pend_addr;
      pend_data_nxt = pend_data;
      pend_be_nxt   = pend_be;
      pend_v_nxt    = pv;
      push_v        = 1'b0;
      push_addr     = pend_addr;
      push_data     = pend_data;
      push_be       = pend_be;

      if (state == S_FLUSH && pend_v) begin
         push_v     = 1'b1;
         pend_v_nxt = 1'b0;
      end

      if (byte_v) begin
         if (pv && byte_waddr == pend_addr) begin
            if (merged_be == 2'b11) begin
               push_v     = 1'b1;
               push_data  = merged_data;
               push_be    = merged_be;
               pend_v_nxt = 1'b0;
            end else begin
               pend_data_nxt = merged_data;
               pend_be_nxt   = merged_be;
            end
         end else begin
            if (pv) push_v = 1'b1;
            pend_addr_nxt = byte_waddr;
            pend_data_nxt = lane_data;
            pend_be_nxt   = lane_be;
            pend_v_nxt    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         pend_addr <= '0;
         pend_data <= '0;
         pend_be   <= '0;
         pend_v    <= 1'b0;
      end else begin
         pend_addr <= pend_addr_nxt;
         pend_data <= pend_data_nxt;
         pend_be   <= pend_be_nxt;
         pend_v    <= pend_v_nxt;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (push_ok) fifo_mem[wr_ptr[FIFO_AW-1:0]] <= {push_addr, push_data, push_be};
   end

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // The head stays in the FIFO until acknowledged; the output registers only mirror it.
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         mem_req  <= 1'b0;
         mem_addr <= '0;
         mem_din  <= '0;
         mem_be   <= '0;
      end else if (!mem_req && !fifo_empty) begin
         mem_req                     <= 1'b1;
         {mem_addr, mem_din, mem_be} <= head;
      end else if (pop) begin
         mem_req <= 1'b0;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         overflow <= 1'b0;
      end else begin
         if (rise) overflow <= 1'b0;
         if (drop) overflow <= 1'b1;
      end
   end

`ifdef IOCTL_PACKER_STATS_EN
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         stat_words <= '0;
      end else if (rise) begin
         stat_words <= '0;
      end else if (pop) begin
         stat_words <= stat_words + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ioctl_word_packer.sv
// Directed self-checking bench for ioctl_word_packer; builds with or without IOCTL_PACKER_STATS_EN.
module tb_ioctl_word_packer;

   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b0;
   logic        ioctl_download = 1'b0;
   logic        ioctl_wr = 1'b0;
   logic [24:0] ioctl_addr = '0;
   logic [7:0]  ioctl_dout = '0;
   logic        mem_req;
   logic        mem_ack = 1'b0;
   logic [23:0] mem_addr;
   logic [15:0] mem_din;
   logic [1:0]  mem_be;
   logic        busy;
   logic        done;
   logic        overflow;
`ifdef IOCTL_PACKER_STATS_EN
   logic [15:0] stat_words;
`endif

   int tests_run = 0;
   int tests_failed = 0;
   int done_cnt = 0;

   ioctl_word_packer #(.FIFO_AW(3), .ADDR_W(25)) dut (
      .clk_sys(clk_sys),
      .reset_n(reset_n),
      .ioctl_download(ioctl_download),
      .ioctl_wr(ioctl_wr),
      .ioctl_addr(ioctl_addr),
      .ioctl_dout(ioctl_dout),
      .mem_req(mem_req),
      .mem_ack(mem_ack),
      .mem_addr(mem_addr),
      .mem_din(mem_din),
      .mem_be(mem_be),
      .busy(busy),
      .done(done),
      .overflow(overflow)
`ifdef IOCTL_PACKER_STATS_EN
      ,
      .stat_words(stat_words)
`endif
   );

   always #5 clk_sys = ~clk_sys;

   always @(negedge clk_sys) begin
      if (done === 1'b1) done_cnt++;
   end

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
      ioctl_addr = a;
      ioctl_dout = d;
      ioctl_wr   = 1'b1;
      tick();
      ioctl_wr   = 1'b0;
   endtask

   task automatic wait_req(input int budget, output bit got);
      got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         if (mem_req === 1'b1) got = 1'b1;
         else tick();
      end
   endtask

   task automatic ack_word(output logic [23:0] a, output logic [15:0] d, output logic [1:0] be);
      a       = mem_addr;
      d       = mem_din;
      be      = mem_be;
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      tests_run++; if (mem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_mem_req: got %0h expected 0", mem_req); end
      tests_run++; if (mem_addr !== 24'h0) begin tests_failed++; $display("[TB] FAIL reset_mem_addr: got %0h expected 0", mem_addr); end
      tests_run++; if (mem_din !== 16'h0) begin tests_failed++; $display("[TB] FAIL reset_mem_din: got %0h expected 0", mem_din); end
      tests_run++; if (mem_be !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_mem_be: got %0h expected 0", mem_be); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %0h expected 0", busy); end
      tests_run++; if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done: got %0h expected 0", done); end
      tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_overflow: got %0h expected 0", overflow); end
`ifdef IOCTL_PACKER_STATS_EN
      tests_run++; if (stat_words !== 16'h0) begin tests_failed++; $display("[TB] FAIL reset_stat_words: got %0h expected 0", stat_words); end
`endif
   endtask

   task automatic test_full_words();
      logic [23:0] exp_a [2] = '{24'h0, 24'h1};
      logic [15:0] exp_d [2] = '{16'h2211, 16'h4433};
      logic [23:0] a;
      logic [15:0] d;
      logic [1:0]  be;
      bit          got;
      int          d0 = done_cnt;
      ioctl_download = 1'b1;
      tick();
      send_byte(25'h0, 8'h11);
      send_byte(25'h1, 8'h22);
      tests_run++; if (mem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL latency_early: got %0h expected 0", mem_req); end
      send_byte(25'h2, 8'h33);
      tests_run++; if (mem_req !== 1'b1) begin tests_failed++; $display("[TB] FAIL latency_req: got %0h expected 1", mem_req); end
      send_byte(25'h3, 8'h44);
      ioctl_download = 1'b0;
      tick();
      for (int k = 0; k < 2; k++) begin
         wait_req(10, got);
         tests_run++;
         if (!got) begin
            tests_failed++; $display("[TB] FAIL full_req_timeout: got 0 expected 1 (word %0d)", k);
         end else begin
            ack_word(a, d, be);
            if (a !== exp_a[k]) begin tests_failed++; $display("[TB] FAIL full_addr: got %0h expected %0h", a, exp_a[k]); end
            tests_run++; if (d !== exp_d[k]) begin tests_failed++; $display("[TB] FAIL full_din: got %0h expected %0h", d, exp_d[k]); end
            tests_run++; if (be !== 2'b11) begin tests_failed++; $display("[TB] FAIL full_be: got %0h expected 3", be); end
         end
      end
      repeat (5) tick();
      tests_run++; if (done_cnt - d0 !== 1) begin tests_failed++; $display("[TB] FAIL full_done_count: got %0d expected 1", done_cnt - d0); end
   endtask

   task automatic test_partial_word();
      logic [23:0] a;
      logic [15:0] d;
      logic [1:0]  be;
      bit          got;
      int          d0 = done_cnt;
      ioctl_download = 1'b1;
      tick();
      send_byte(25'h100, 8'hAA);
      send_byte(25'h101, 8'hBB);
      send_byte(25'h102, 8'hCC);
      ioctl_download = 1'b0;
      tick();
      wait_req(10, got);
      tests_run++;
      if (!got) begin
         tests_failed++; $display("[TB] FAIL partial_req0_timeout: got 0 expected 1");
      end else begin
         ack_word(a, d, be);
         if (a !== 24'h80 || d !== 16'hBBAA || be !== 2'b11) begin
            tests_failed++; $display("[TB] FAIL partial_word0: got %0h/%0h/%0h expected 80/bbaa/3", a, d, be);
         end
      end
      wait_req(10, got);
      tests_run++;
      if (!got) begin
         tests_failed++; $display("[TB] FAIL partial_req1_timeout: got 0 expected 1");
      end else begin
         ack_word(a, d, be);
         if (a !== 24'h81) begin tests_failed++; $display("[TB] FAIL partial_addr: got %0h expected 81", a); end
         tests_run++; if (d[7:0] !== 8'hCC) begin tests_failed++; $display("[TB] FAIL partial_din: got %0h expected cc", d[7:0]); end
         tests_run++; if (be !== 2'b01) begin tests_failed++; $display("[TB] FAIL partial_be: got %0h expected 1", be); end
      end
      repeat (5) tick();
      tests_run++; if (done_cnt - d0 !== 1) begin tests_failed++; $display("[TB] FAIL partial_done_count: got %0d expected 1", done_cnt - d0); end
   endtask

   task automatic test_odd_jump();
      logic [23:0] a;
      logic [15:0] d;
      logic [1:0]  be;
      bit          got;
      ioctl_download = 1'b1;
      tick();
      send_byte(25'h5, 8'h55);
      send_byte(25'h8, 8'h66);
      ioctl_download = 1'b0;
      tick();
      wait_req(10, got);
      tests_run++;
      if (!got) begin
         tests_failed++; $display("[TB] FAIL odd_req0_timeout: got 0 expected 1");
      end else begin
         ack_word(a, d, be);
         if (a !== 24'h2) begin tests_failed++; $display("[TB] FAIL odd_addr: got %0h expected 2", a); end
         tests_run++; if (d[15:8] !== 8'h55) begin tests_failed++; $display("[TB] FAIL odd_din_hi: got %0h expected 55", d[15:8]); end
         tests_run++; if (be !== 2'b10) begin tests_failed++; $display("[TB] FAIL odd_be: got %0h expected 2", be); end
      end
      wait_req(10, got);
      tests_run++;
      if (!got) begin
         tests_failed++; $display("[TB] FAIL jump_req_timeout: got 0 expected 1");
      end else begin
         ack_word(a, d, be);
         if (a !== 24'h4) begin tests_failed++; $display("[TB] FAIL jump_addr: got %0h expected 4", a); end
         tests_run++; if (be !== 2'b01 || d[7:0] !== 8'h66) begin tests_failed++; $display("[TB] FAIL jump_be_din: got %0h/%0h expected 1/66", be, d[7:0]); end
      end
      repeat (5) tick();
   endtask

   task automatic test_overflow();
      logic [23:0] a, last_a;
      logic [15:0] d, last_d;
      logic [1:0]  be;
      bit          got;
      int          n = 0;
      last_a = '0;
      last_d = '0;
      ioctl_download = 1'b1;
      mem_ack = 1'b0;
      tick();
      for (int i = 0; i < 20; i++) begin
         send_byte(25'(i), 8'(i));
         if (i == 15) begin
            tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL ovf_early: got %0h expected 0", overflow); end
         end
         if (i == 17) begin
            tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovf_set: got %0h expected 1", overflow); end
         end
      end
      ioctl_download = 1'b0;
      tick();
      for (int k = 0; k < 12; k++) begin
         wait_req(8, got);
         if (!got) break;
         ack_word(a, d, be);
         last_a = a;
         last_d = d;
         n++;
      end
      tests_run++; if (n !== 8) begin tests_failed++; $display("[TB] FAIL ovf_delivered: got %0d expected 8", n); end
      tests_run++; if (last_a !== 24'h7 || last_d !== 16'h0F0E) begin tests_failed++; $display("[TB] FAIL ovf_last_word: got %0h/%0h expected 7/0f0e", last_a, last_d); end
      tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovf_sticky: got %0h expected 1", overflow); end
      ioctl_download = 1'b1;
      tick();
      tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL ovf_clear: got %0h expected 0", overflow); end
      ioctl_download = 1'b0;
      repeat (6) tick();
   endtask

   task automatic test_reset_mid();
      int d0;
      ioctl_download = 1'b1;
      mem_ack = 1'b0;
      tick();
      for (int i = 0; i < 6; i++) send_byte(25'h10 + 25'(i), 8'hA0 + 8'(i));
      ioctl_download = 1'b0;
      tick();
      tick();
      tests_run++; if (mem_req !== 1'b1) begin tests_failed++; $display("[TB] FAIL mid_pre_req: got %0h expected 1", mem_req); end
      d0 = done_cnt;
      reset_n = 1'b0;
      tick();
      tests_run++; if (mem_req !== 1'b0 || mem_addr !== 24'h0 || mem_din !== 16'h0 || mem_be !== 2'b00) begin
         tests_failed++; $display("[TB] FAIL mid_outputs: got %0h/%0h/%0h/%0h expected 0/0/0/0", mem_req, mem_addr, mem_din, mem_be);
      end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_busy: got %0h expected 0", busy); end
      reset_n = 1'b1;
      repeat (5) tick();
      tests_run++; if (done_cnt !== d0) begin tests_failed++; $display("[TB] FAIL mid_no_done: got %0d expected %0d", done_cnt, d0); end
      tests_run++; if (mem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_req_after: got %0h expected 0", mem_req); end
   endtask

`ifdef IOCTL_PACKER_STATS_EN
   task automatic test_stats();
      logic [23:0] a;
      logic [15:0] d;
      logic [1:0]  be;
      bit          got;
      ioctl_download = 1'b1;
      tick();
      tests_run++; if (stat_words !== 16'h0) begin tests_failed++; $display("[TB] FAIL stats_start: got %0h expected 0", stat_words); end
      for (int i = 0; i < 12; i++) send_byte(25'h200 + 25'(i), 8'(i));
      ioctl_download = 1'b0;
      tick();
      for (int k = 0; k < 6; k++) begin
         wait_req(10, got);
         if (!got) break;
         ack_word(a, d, be);
      end
      repeat (4) tick();
      tests_run++; if (stat_words !== 16'd6) begin tests_failed++; $display("[TB] FAIL stats_count: got %0d expected 6", stat_words); end
      ioctl_download = 1'b1;
      tick();
      tests_run++; if (stat_words !== 16'h0) begin tests_failed++; $display("[TB] FAIL stats_clear: got %0d expected 0", stat_words); end
      ioctl_download = 1'b0;
      repeat (6) tick();
   endtask
`endif

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      test_reset();
      test_full_words();
      test_partial_word();
      test_odd_jump();
      test_overflow();
      test_reset_mid();
`ifdef IOCTL_PACKER_STATS_EN
      test_stats();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
